// File: rtl/memory_bus_arbiter_if.sv
// memory_bus_arbiter_if: bus bundle between the two requesters (core, host),
// the arbiter and the single fixed-latency memory port.
//   slave  : arbiter view (takes requests, drives acks and the memory strobes)
//   master : requester/memory view (drives requests and memory read data)
interface memory_bus_arbiter_if;
    // core requester
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_ack;
    logic [31:0] core_rdata;
    // host / controller requester
    logic        host_req;
    logic        host_we;
    logic [31:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic [31:0] host_rdata;
    logic        host_lock;
    // memory port
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    // status
    logic        busy;
    logic        grant;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_ack, core_rdata,
        input  host_req, host_we, host_addr, host_wdata, host_lock,
        output host_ack, host_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, grant
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_ack, core_rdata,
        output host_req, host_we, host_addr, host_wdata, host_lock,
        input  host_ack, host_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, grant
    );
endinterface

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: shares one fixed-latency memory port between the core
// (port 0) and the host/controller path (port 1). One transaction at a time:
// IDLE -> ACCESS (MEM_LATENCY cycles of strobe) -> RESP (one-cycle ack) -> IDLE.
// Optional feature macro: ARBITER_ROUND_ROBIN_EN
//   undefined : fixed priority, host wins every tie
//   defined   : ties go to the port not granted last time (first tie -> core)
module memory_bus_arbiter #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    memory_bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Strobe cycles remaining after the current one; loaded on grant.
    localparam logic [3:0] COUNT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state_r;
    logic [3:0]  count_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] rdata_r;
    logic        mem_read_r;
    logic        mem_write_r;
    logic        core_ack_r;
    logic        host_ack_r;
    logic        busy_r;
    logic        grant_r;
`ifdef ARBITER_ROUND_ROBIN_EN
    logic        last_grant_r;
`endif

    logic        core_eligible_s;
    logic        host_eligible_s;
    logic        any_eligible_s;
    logic        pick_host_s;
    logic        sel_we_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;

    // Eligibility, winner selection and the winner's request fields.
    always_comb begin
        core_eligible_s = bus.core_req & ~bus.host_lock;
        host_eligible_s = bus.host_req;
        any_eligible_s  = core_eligible_s | host_eligible_s;
`ifdef ARBITER_ROUND_ROBIN_EN
        if (core_eligible_s && host_eligible_s) begin
            pick_host_s = ~last_grant_r;
        end else begin
            pick_host_s = host_eligible_s;
        end
`else
        pick_host_s = host_eligible_s;
`endif
        if (pick_host_s) begin
            sel_we_s    = bus.host_we;
            sel_addr_s  = bus.host_addr;
            sel_wdata_s = bus.host_wdata;
        end else begin
            sel_we_s    = bus.core_we;
            sel_addr_s  = bus.core_addr;
            sel_wdata_s = bus.core_wdata;
        end
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            count_r      <= 4'd0;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            rdata_r      <= 32'd0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            core_ack_r   <= 1'b0;
            host_ack_r   <= 1'b0;
            busy_r       <= 1'b0;
            grant_r      <= 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
            last_grant_r <= 1'b1;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    core_ack_r <= 1'b0;
                    host_ack_r <= 1'b0;
                    if (any_eligible_s) begin
                        grant_r      <= pick_host_s;
`ifdef ARBITER_ROUND_ROBIN_EN
                        last_grant_r <= pick_host_s;
`endif
                        addr_r       <= sel_addr_s;
                        wdata_r      <= sel_wdata_s;
                        mem_read_r   <= ~sel_we_s;
                        mem_write_r  <= sel_we_s;
                        count_r      <= COUNT_INIT;
                        busy_r       <= 1'b1;
                        state_r      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (count_r == 4'd0) begin
                        // Last strobe cycle: memory data is valid now.
                        if (mem_read_r) begin
                            rdata_r <= bus.mem_rdata;
                        end
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        core_ack_r  <= ~grant_r;
                        host_ack_r  <= grant_r;
                        state_r     <= RESP;
                    end else begin
                        count_r <= count_r - 4'd1;
                    end
                end
                RESP: begin
                    core_ack_r <= 1'b0;
                    host_ack_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    core_ack_r  <= 1'b0;
                    host_ack_r  <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_read   = mem_read_r;
    assign bus.mem_write  = mem_write_r;
    assign bus.mem_addr   = addr_r;
    assign bus.mem_wdata  = wdata_r;
    assign bus.core_ack   = core_ack_r;
    assign bus.host_ack   = host_ack_r;
    assign bus.core_rdata = rdata_r;
    assign bus.host_rdata = rdata_r;
    assign bus.busy       = busy_r;
    assign bus.grant      = grant_r;

endmodule
